// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial 8-bit ALU sequencer and the
// external 4-bit ALU it drives: op-code encoding and sequencer FSM states.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_INC = 3'b110,
        OP_DEC = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,
        ST_HI   = 3'd2,
        ST_FIX  = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    // ADD/SUB need the low-nibble carry/borrow folded into the high nibble.
    function automatic logic is_addsub(input alu_op_e op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // INC/DEC only ripple into the high nibble when the low nibble wrapped.
    function automatic logic is_incdec(input alu_op_e op);
        return (op == OP_INC) || (op == OP_DEC);
    endfunction

endpackage

// File: rtl/alu_seq_8bit.sv
// Sequences an 8-bit operation over an external combinational 4-bit ALU:
// low nibble, high nibble, then an optional fix-up pass that applies the
// low-nibble carry/borrow to the high nibble for ADD/SUB.
module alu_seq_8bit
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [3:0] alu_result,
    input  logic       alu_carry,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_carry
);

    state_e     state, state_nxt;
    alu_op_e    op_q;
    logic [7:0] a_q, b_q, data_q;
    logic       c0_q, c1_q, c2_q;
    logic       accept;

    // Carry reported with the response; logic ops never produce one.
    function automatic logic final_carry(input alu_op_e op, input logic c1, input logic c2);
        if (is_addsub(op)) return c1 | c2;
        if (is_incdec(op)) return c1;
        return 1'b0;
    endfunction

    // Handshake: ready while idle, or while a response is being consumed.
    always_comb begin
        cmd_ready = rst_n && ((state == ST_IDLE) || ((state == ST_RESP) && rsp_ready));
        accept    = cmd_valid && cmd_ready;
        rsp_valid = (state == ST_RESP);
        rsp_data  = rsp_valid ? data_q : 8'h00;
        rsp_carry = rsp_valid ? final_carry(op_q, c1_q, c2_q) : 1'b0;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic and ALU drive for each nibble pass.
    always_comb begin
        state_nxt = state;
        alu_a     = 4'h0;
        alu_b     = 4'h0;
        alu_sel   = 3'b000;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_LO;
            end
            ST_LO: begin
                alu_a     = a_q[3:0];
                alu_b     = b_q[3:0];
                alu_sel   = op_q;
                state_nxt = ST_HI;
            end
            ST_HI: begin
                alu_a = a_q[7:4];
                if (is_incdec(op_q)) begin
                    // Without a low-nibble wrap the high nibble passes through (A+0).
                    alu_b   = 4'h0;
                    alu_sel = c0_q ? op_q : OP_ADD;
                end else begin
                    alu_b   = b_q[7:4];
                    alu_sel = op_q;
                end
                state_nxt = (is_addsub(op_q) && c0_q) ? ST_FIX : ST_RESP;
            end
            ST_FIX: begin
                alu_a     = data_q[7:4];
                alu_b     = 4'h0;
                alu_sel   = (op_q == OP_ADD) ? OP_INC : OP_DEC;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) state_nxt = accept ? ST_LO : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand latch and per-pass result/carry capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= OP_ADD;
            a_q    <= 8'h00;
            b_q    <= 8'h00;
            data_q <= 8'h00;
            c0_q   <= 1'b0;
            c1_q   <= 1'b0;
            c2_q   <= 1'b0;
        end else if (accept) begin
            op_q   <= alu_op_e'(cmd_op);
            a_q    <= cmd_a;
            b_q    <= cmd_b;
            data_q <= 8'h00;
            c0_q   <= 1'b0;
            c1_q   <= 1'b0;
            c2_q   <= 1'b0;
        end else begin
            case (state)
                ST_LO: begin
                    data_q[3:0] <= alu_result;
                    c0_q        <= alu_carry;
                end
                ST_HI: begin
                    data_q[7:4] <= alu_result;
                    c1_q        <= alu_carry;
                end
                ST_FIX: begin
                    data_q[7:4] <= alu_result;
                    c2_q        <= alu_carry;
                end
                default: ;
            endcase
        end
    end

endmodule
